// File: rtl/vga_line_prefetch.sv
// rtl/vga_line_prefetch.sv - ping-pong line buffer prefetcher feeding vga_ctrl from frame-buffer memory
module vga_line_prefetch #(
    parameter int          H_VALID         = 800,
    parameter int          V_VALID         = 600,
    parameter logic [19:0] FB_BASE         = 20'h00000,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [11:0] UNDERRUN_RGB    = 12'hF00
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic        vsync,
    output logic [11:0] pix_data,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [11:0] mem_rdata,
    output logic        busy,
    output logic        underrun,
    output logic        overrun,
    input  logic        clr_status
);

    localparam int AW = (H_VALID > 1) ? $clog2(H_VALID) : 1;
    localparam int PW = $clog2(H_VALID + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PW-1:0] H_END     = PW'(H_VALID);
    localparam logic [PW-1:0] H_LAST    = PW'(H_VALID - 1);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
    localparam logic [11:0]   X_END     = 12'(H_VALID);
    localparam logic [11:0]   Y_LAST    = 12'(V_VALID - 1);
    localparam logic [11:0]   NO_REQ    = 12'hfff;
    localparam logic [19:0]   LINE_STEP = 20'(H_VALID);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        PK_ZERO,
        PK_RAM,
        PK_UNDER
    } pix_kind_t;

    state_t         state;
    pix_kind_t      pix_kind;
    logic           vsync_d;
    logic [1:0]     buf_ready;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  outstanding_next;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  rd_ptr_next;
    logic [PW-1:0]  wr_ptr;
    logic           target;
    logic [19:0]    line_addr;
    logic           aborted;
    logic           pend_target;

    logic [11:0]    buf0 [H_VALID];
    logic [11:0]    buf1 [H_VALID];
    logic [11:0]    ram_q;

    logic           frame_trig;
    logic           line_trig;
    logic           trig;
    logic           trig_target;
    logic [19:0]    trig_addr;
    logic           grant;
    logic           ret;
    logic           abort_now;
    logic           wr_en;
    logic           pix_hit;
    logic [AW-1:0]  rd_idx;

    always_comb begin
        frame_trig  = enable && vsync && !vsync_d;
        line_trig   = enable && (pix_x == 12'd0) && (pix_y != NO_REQ) && (pix_y < Y_LAST);
        trig        = frame_trig || line_trig;
        // Next line lands in the buffer selected by the parity of pix_y+1.
        trig_target = frame_trig ? 1'b0 : ~pix_y[0];
        trig_addr   = frame_trig ? FB_BASE : line_addr + LINE_STEP;
    end

    assign busy    = (state != ST_IDLE);
    assign mem_req = (state == ST_REQ) && !aborted && (rd_ptr < H_END) && (outstanding < OUT_MAX);
    assign mem_addr = mem_req ? line_addr + 20'(rd_ptr) : 20'd0;

    always_comb begin
        grant            = mem_req && mem_gnt;
        ret              = mem_rvalid && (outstanding != '0);
        outstanding_next = outstanding;
        if (grant && !ret) begin
            outstanding_next = outstanding + OW'(1);
        end else if (!grant && ret) begin
            outstanding_next = outstanding - OW'(1);
        end
        rd_ptr_next = grant ? rd_ptr + PW'(1) : rd_ptr;
        // A trigger arriving while busy already poisons this cycle's return.
        abort_now   = aborted || (busy && trig);
        wr_en       = ret && busy && !abort_now && (wr_ptr < H_END);
        pix_hit     = buf_ready[pix_y[0]] && (pix_x < X_END);
        rd_idx      = pix_x[AW-1:0];
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            vsync_d     <= 1'b0;
            buf_ready   <= 2'b00;
            outstanding <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            target      <= 1'b0;
            line_addr   <= 20'd0;
            aborted     <= 1'b0;
            pend_target <= 1'b0;
        end else begin
            vsync_d     <= vsync;
            outstanding <= outstanding_next;
            rd_ptr      <= rd_ptr_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (wr_ptr == H_LAST) begin
                    buf_ready[target] <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state                  <= ST_REQ;
                        target                 <= trig_target;
                        buf_ready[trig_target] <= 1'b0;
                        rd_ptr                 <= '0;
                        wr_ptr                 <= '0;
                        aborted                <= 1'b0;
                        line_addr              <= trig_addr;
                    end
                end
                default: begin
                    if (trig) begin
                        aborted     <= 1'b1;
                        pend_target <= trig_target;
                        line_addr   <= trig_addr;
                    end
                    if (abort_now) begin
                        // Only once every stale return has been swallowed may the newest trigger start.
                        if (outstanding_next == '0) begin
                            state     <= ST_REQ;
                            target    <= trig ? trig_target : pend_target;
                            buf_ready[trig ? trig_target : pend_target] <= 1'b0;
                            rd_ptr    <= '0;
                            wr_ptr    <= '0;
                            aborted   <= 1'b0;
                        end
                    end else if (state == ST_REQ) begin
                        if (rd_ptr_next == H_END) begin
                            state <= ST_DRAIN;
                        end
                    end else if (outstanding_next == '0) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
            pix_kind <= PK_ZERO;
        end else begin
            if ((pix_x != NO_REQ) && !pix_hit) begin
                underrun <= 1'b1;
            end else if (clr_status) begin
                underrun <= 1'b0;
            end
            if (busy && trig) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
            if (pix_x == NO_REQ) begin
                pix_kind <= PK_ZERO;
            end else if (pix_hit) begin
                pix_kind <= PK_RAM;
            end else begin
                pix_kind <= PK_UNDER;
            end
        end
    end

    // Line RAMs are not reset; nonblocking write gives read-before-write on a shared address.
    always_ff @(posedge vga_clk) begin
        if (wr_en && !target) begin
            buf0[wr_ptr[AW-1:0]] <= mem_rdata;
        end
        if (wr_en && target) begin
            buf1[wr_ptr[AW-1:0]] <= mem_rdata;
        end
        ram_q <= pix_y[0] ? buf1[rd_idx] : buf0[rd_idx];
    end

    always_comb begin
        case (pix_kind)
            PK_RAM:   pix_data = ram_q;
            PK_UNDER: pix_data = UNDERRUN_RGB;
            default:  pix_data = 12'd0;
        endcase
    end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb/tb_vga_line_prefetch.sv - scoreboard bench for vga_line_prefetch with a request-ordered memory model
module tb_vga_line_prefetch;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        vsync;
    logic [11:0] pix_data;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid = 1'b0;
    logic [11:0] mem_rdata  = 12'd0;
    logic        busy;
    logic        underrun;
    logic        overrun;
    logic        clr_status;

    vga_line_prefetch dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .vsync      (vsync),
        .pix_data   (pix_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .underrun   (underrun),
        .overrun    (overrun),
        .clr_status (clr_status)
    );

    always #5 vga_clk = ~vga_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [19:0] fifo[$];
    logic [19:0] exp_addr[$];
    logic [11:0] exp_pix[$];
    bit          hold    = 1'b0;
    int          rel_cnt = 0;
    int          grants  = 0;
    int          stray   = 0;
    int          cyc     = 0;
    int          first_g = -1;
    int          last_g  = -1;

    // Memory: returns data = addr[11:0] one cycle after each grant, in order, unless held.
    always @(negedge vga_clk) begin
        logic [19:0] a;
        #1;
        cyc++;
        if (!rst_n) begin
            fifo.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = 12'd0;
        end else begin
            mem_rvalid = 1'b0;
            if (fifo.size() > 0 && (!hold || rel_cnt > 0)) begin
                a          = fifo.pop_front();
                mem_rdata  = a[11:0];
                mem_rvalid = 1'b1;
                if (hold) rel_cnt--;
            end
            if (mem_req && mem_gnt) begin
                fifo.push_back(mem_addr);
                grants++;
                if (first_g < 0) first_g = cyc;
                last_g = cyc;
                if (exp_addr.size() > 0) chk("addr", mem_addr, exp_addr.pop_front());
                else stray++;
            end
        end
    end

    task automatic pixel(input logic [11:0] x, input logic [11:0] y, input logic [11:0] e);
        pix_x = x;
        pix_y = y;
        exp_pix.push_back(e);
        @(negedge vga_clk);
        pix_x = 12'hfff;
        pix_y = 12'hfff;
        chk("pix", pix_data, exp_pix.pop_front());
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        @(negedge vga_clk);
        while (busy && n < budget) begin
            @(negedge vga_clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic clr_pulse();
        clr_status = 1'b1;
        @(negedge vga_clk);
        clr_status = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        enable     = 1'b1;
        vsync      = 1'b1;
        pix_x      = 12'hfff;
        pix_y      = 12'hfff;
        mem_gnt    = 1'b0;
        clr_status = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge vga_clk);
        chk("rst_pix", pix_data, 12'd0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 20'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_under", underrun, 1'b0);
        chk("rst_over", overrun, 1'b0);

        // Frame trigger straight out of reset: line 0 at full rate.
        for (int i = 0; i < 800; i++) exp_addr.push_back(20'(i));
        mem_gnt = 1'b1;
        rst_n   = 1'b1;
        wait_idle(2000, "fetch0");
        chk("fetch0_grants", grants, 800);
        chk("fetch0_span", last_g - first_g, 799);
        chk("fetch0_drained", fifo.size(), 0);
        chk("fetch0_addrq", exp_addr.size(), 0);
        pixel(12'd5, 12'd0, 12'h005);
        pixel(12'd799, 12'd0, 12'h31f);
        pixel(12'hfff, 12'd0, 12'h000);
        chk("no_under", underrun, 1'b0);

        pixel(12'd3, 12'd1, 12'hf00);
        chk("under_set", underrun, 1'b1);
        clr_pulse();
        chk("under_clr", underrun, 1'b0);

        // Last line never triggers a fetch.
        g0 = grants;
        pixel(12'd0, 12'd599, 12'hf00);
        repeat (4) @(negedge vga_clk);
        chk("y599_busy", busy, 1'b0);
        chk("y599_grants", grants - g0, 0);
        clr_pulse();

        // Line 1 fetch with returns withheld: capped at MAX_OUTSTANDING.
        hold    = 1'b1;
        rel_cnt = 0;
        g0      = grants;
        for (int i = 800; i < 1600; i++) exp_addr.push_back(20'(i));
        pixel(12'd0, 12'd0, 12'h000);
        repeat (20) @(negedge vga_clk);
        chk("cap_grants", grants - g0, 8);
        chk("cap_req", mem_req, 1'b0);
        rel_cnt = 1;
        repeat (10) @(negedge vga_clk);
        chk("cap_one_more", grants - g0, 9);
        chk("cap_req2", mem_req, 1'b0);
        pixel(12'd4, 12'd1, 12'hf00);
        chk("under_line1", underrun, 1'b1);
        clr_pulse();

        // Frame trigger mid-fetch with 3 reads in flight.
        mem_gnt = 1'b0;
        rel_cnt = 5;
        repeat (10) @(negedge vga_clk);
        exp_addr.delete();
        for (int i = 0; i < 800; i++) exp_addr.push_back(20'(i));
        vsync = 1'b0;
        @(negedge vga_clk);
        vsync = 1'b1;
        @(negedge vga_clk);
        chk("over_set", overrun, 1'b1);
        chk("over_busy", busy, 1'b1);
        hold    = 1'b0;
        mem_gnt = 1'b1;
        wait_idle(2000, "refetch");
        chk("refetch_addrq", exp_addr.size(), 0);
        pixel(12'd1, 12'd0, 12'h001);
        pixel(12'd2, 12'd0, 12'h002);
        pixel(12'd799, 12'd0, 12'h31f);
        clr_pulse();
        chk("over_clr", overrun, 1'b0);

        // Asynchronous reset in the middle of REQ.
        exp_addr.delete();
        for (int i = 800; i < 1600; i++) exp_addr.push_back(20'(i));
        pixel(12'd0, 12'd0, 12'h000);
        repeat (5) @(negedge vga_clk);
        chk("mid_req", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_addr", mem_addr, 20'd0);
        vsync = 1'b0;
        repeat (2) @(negedge vga_clk);
        exp_addr.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_pix", pix_data, 12'd0);
        chk("stray_grants", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
